// File: rtl/dh_key_sequencer.sv
// Diffie-Hellman key sequencer: k = base^priv mod p by square-and-multiply, then a go/verdict
// handshake with the encryption stage. Define DH_SKIP_LEAD_ZERO_EN to skip leading-zero squarings.
module dh_key_sequencer #(
    parameter int unsigned EXP_W   = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      base,
    input  logic [EXP_W-1:0] priv,
    input  logic [31:0]      p,
    output logic             busy,
    output logic [63:0]      key,
    output logic             key_vld,
    output logic             enc_go,
    input  logic             enc_rsp_vld,
    input  logic             enc_true,
    output logic             done,
    output logic             pass,
    output logic             err
);
    localparam int unsigned IdxW = (EXP_W > 1) ? $clog2(EXP_W) : 1;
    localparam int unsigned TmrW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StSq,
        StMul,
        StIssue,
        StWait,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      base_q, base_d;
    logic [EXP_W-1:0] priv_q, priv_d;
    logic [31:0]      p_q, p_d;
    logic [31:0]      b_q, b_d;
    logic [31:0]      acc_q, acc_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic [TmrW-1:0]  timer_q, timer_d;
    logic [31:0]      key_q, key_d;
    logic             key_vld_q, key_vld_d;
    logic             enc_go_q, enc_go_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;

    // One shared 64/32 modulo unit: reduces base in LOAD, acc*acc in SQ, acc*b in MUL.
    logic [31:0] mul_op;
    logic [31:0] mod_div;
    logic [31:0] mod_res;
    logic [63:0] mod_num;

    always_comb begin
        mul_op  = (state_q == StMul) ? b_q : acc_q;
        mod_num = (state_q == StLoad) ? {32'd0, base_q}
                                      : ({32'd0, acc_q} * {32'd0, mul_op});
        // Divisor forced non-zero so the unit never divides by zero when p is invalid.
        mod_div = (p_q < 32'd2) ? 32'd1 : p_q;
        mod_res = 32'(mod_num % {32'd0, mod_div});
    end

`ifdef DH_SKIP_LEAD_ZERO_EN
    logic [IdxW-1:0] msb_idx;

    always_comb begin
        msb_idx = '0;
        for (int i = 0; i < int'(EXP_W); i++) begin
            if (priv_q[i]) begin
                msb_idx = IdxW'(i);
            end
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        priv_d    = priv_q;
        p_d       = p_q;
        b_d       = b_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        timer_d   = timer_q;
        key_d     = key_q;
        key_vld_d = key_vld_q;
        enc_go_d  = 1'b0;
        done_d    = 1'b0;
        pass_d    = pass_q;
        err_d     = err_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    base_d    = base;
                    priv_d    = priv;
                    p_d       = p;
                    key_d     = 32'd0;
                    key_vld_d = 1'b0;
                    pass_d    = 1'b0;
                    err_d     = 1'b0;
                    state_d   = StLoad;
                end
            end
            StLoad: begin
                if (p_q < 32'd2) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    b_d   = mod_res;
                    acc_d = 32'd1;
`ifdef DH_SKIP_LEAD_ZERO_EN
                    if (priv_q == '0) begin
                        state_d = StIssue;
                    end else begin
                        idx_d   = msb_idx;
                        state_d = StSq;
                    end
`else
                    idx_d   = IdxW'(EXP_W - 1);
                    state_d = StSq;
`endif
                end
            end
            StSq: begin
                acc_d = mod_res;
                if (priv_q[idx_q]) begin
                    state_d = StMul;
                end else if (idx_q == '0) begin
                    state_d = StIssue;
                end else begin
                    idx_d = idx_q - IdxW'(1);
                end
            end
            StMul: begin
                acc_d = mod_res;
                if (idx_q == '0) begin
                    state_d = StIssue;
                end else begin
                    idx_d   = idx_q - IdxW'(1);
                    state_d = StSq;
                end
            end
            StIssue: begin
                key_d     = acc_q;
                key_vld_d = 1'b1;
                enc_go_d  = 1'b1;
                timer_d   = '0;
                state_d   = StWait;
            end
            StWait: begin
                // A response on the terminal-count cycle still wins over the timeout.
                if (enc_rsp_vld) begin
                    pass_d  = enc_true;
                    err_d   = 1'b0;
                    state_d = StDone;
                end else if (timer_q == TmrW'(TIMEOUT - 1)) begin
                    timer_d = timer_q + TmrW'(1);
                    pass_d  = 1'b0;
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    timer_d = timer_q + TmrW'(1);
                end
            end
            StDone: begin
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            base_q    <= 32'd0;
            priv_q    <= '0;
            p_q       <= 32'd0;
            b_q       <= 32'd0;
            acc_q     <= 32'd0;
            idx_q     <= '0;
            timer_q   <= '0;
            key_q     <= 32'd0;
            key_vld_q <= 1'b0;
            enc_go_q  <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            priv_q    <= priv_d;
            p_q       <= p_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            idx_q     <= idx_d;
            timer_q   <= timer_d;
            key_q     <= key_d;
            key_vld_q <= key_vld_d;
            enc_go_q  <= enc_go_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    assign busy    = busy_q;
    assign key     = {32'd0, key_q};
    assign key_vld = key_vld_q;
    assign enc_go  = enc_go_q;
    assign done    = done_q;
    assign pass    = pass_q;
    assign err     = err_q;

endmodule

// File: tb/tb_dh_key_sequencer.sv
// Directed bench for dh_key_sequencer: key values, go/done timing, bad modulus, timeout, reset.
// Latency expectations follow DH_SKIP_LEAD_ZERO_EN when it is defined.
module tb_dh_key_sequencer;
    localparam int unsigned EXP_W   = 32;
    localparam int unsigned TIMEOUT = 16;
`ifdef DH_SKIP_LEAD_ZERO_EN
    localparam int LAT_P6 = 7;
    localparam int LAT_P1 = 4;
    localparam int LAT_P0 = 2;
`else
    localparam int LAT_P6 = 36;
    localparam int LAT_P1 = 35;
    localparam int LAT_P0 = 34;
`endif

    logic             clk;
    logic             rst;
    logic             start;
    logic [31:0]      base;
    logic [EXP_W-1:0] priv;
    logic [31:0]      p;
    logic             busy;
    logic [63:0]      key;
    logic             key_vld;
    logic             enc_go;
    logic             enc_rsp_vld;
    logic             enc_true;
    logic             done;
    logic             pass;
    logic             err;

    int n_cmp  = 0;
    int n_fail = 0;
    int go_cnt = 0;
    int dn_cnt = 0;

    dh_key_sequencer #(
        .EXP_W  (EXP_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base       (base),
        .priv       (priv),
        .p          (p),
        .busy       (busy),
        .key        (key),
        .key_vld    (key_vld),
        .enc_go     (enc_go),
        .enc_rsp_vld(enc_rsp_vld),
        .enc_true   (enc_true),
        .done       (done),
        .pass       (pass),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (enc_go) go_cnt <= go_cnt + 1;
        if (done)   dn_cnt <= dn_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [31:0] b, input logic [31:0] e, input logic [31:0] m);
        @(negedge clk);
        base  = b;
        priv  = e;
        p     = m;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_go(output int k);
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!enc_go && k < 300);
    endtask

    task automatic wait_done(output int k);
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!done && k < 300);
    endtask

    task automatic respond(input logic verdict);
        enc_rsp_vld = 1'b1;
        enc_true    = verdict;
        @(posedge clk);
        #1;
        enc_rsp_vld = 1'b0;
        enc_true    = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int g;
        int d;
        rst = 1'b1; start = 1'b0; base = '0; priv = '0; p = '0;
        enc_rsp_vld = 1'b0; enc_true = 1'b0;
        #1 rst = 1'b0;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_key", key, 64'd0);
        chk("rst_flags", {58'd0, key_vld, enc_go, done, pass, err, busy}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // 5^6 mod 23 = 8, verdict two cycles after go
        do_start(32'd5, 32'd6, 32'd23);
        chk("t1_busy", 64'(busy), 64'd1);
        wait_go(k);
        chk("t1_go_lat", 64'(k), 64'(LAT_P6));
        chk("t1_key", key, 64'd8);
        chk("t1_key_vld", 64'(key_vld), 64'd1);
        @(posedge clk); #1;
        chk("t1_go_pulse", 64'(enc_go), 64'd0);
        @(posedge clk); #1;
        respond(1'b1);
        chk("t1_done_early", 64'(done), 64'd0);
        @(posedge clk); #1;
        chk("t1_done", 64'(done), 64'd1);
        chk("t1_pass", 64'(pass), 64'd1);
        chk("t1_err", 64'(err), 64'd0);
        chk("t1_idle", 64'(busy), 64'd0);
        @(posedge clk); #1;
        chk("t1_done_pulse", 64'(done), 64'd0);

        // base >= p, fail verdict in the first WAIT cycle
        do_start(32'd27, 32'd1, 32'd23);
        wait_go(k);
        chk("t2_go_lat", 64'(k), 64'(LAT_P1));
        chk("t2_key", key, 64'd4);
        respond(1'b0);
        wait_done(k);
        chk("t2_done_lat", 64'(k), 64'd1);
        chk("t2_pass", 64'(pass), 64'd0);
        chk("t2_err", 64'(err), 64'd0);

        // zero exponent
        do_start(32'd2, 32'd0, 32'd11);
        wait_go(k);
        chk("t3_go_lat", 64'(k), 64'(LAT_P0));
        chk("t3_key", key, 64'd1);
        chk("t3_key_vld", 64'(key_vld), 64'd1);
        respond(1'b1);
        wait_done(k);
        chk("t3_pass", 64'(pass), 64'd1);

        // bad modulus p=1 then p=0
        g = go_cnt;
        do_start(32'd7, 32'd5, 32'd1);
        wait_done(k);
        chk("t4_p1_done_lat", 64'(k), 64'd2);
        chk("t4_p1_err", 64'(err), 64'd1);
        chk("t4_p1_pass", 64'(pass), 64'd0);
        chk("t4_p1_key_vld", 64'(key_vld), 64'd0);
        do_start(32'd7, 32'd5, 32'd0);
        wait_done(k);
        chk("t4_p0_done_lat", 64'(k), 64'd2);
        chk("t4_p0_err", 64'(err), 64'd1);
        chk("t4_p0_key", key, 64'd0);
        @(posedge clk); #1;
        chk("t4_no_go", 64'(go_cnt), 64'(g));

        // no response: timeout
        do_start(32'd5, 32'd6, 32'd23);
        wait_go(k);
        wait_done(k);
        chk("t5_to_lat", 64'(k), 64'(TIMEOUT + 1));
        chk("t5_err", 64'(err), 64'd1);
        chk("t5_pass", 64'(pass), 64'd0);
        chk("t5_key", key, 64'd8);

        // response on the terminal-count cycle wins
        do_start(32'd5, 32'd6, 32'd23);
        wait_go(k);
        repeat (TIMEOUT - 1) begin
            @(posedge clk); #1;
        end
        chk("t6_still_wait", 64'(done), 64'd0);
        respond(1'b1);
        @(posedge clk); #1;
        chk("t6_done", 64'(done), 64'd1);
        chk("t6_pass", 64'(pass), 64'd1);
        chk("t6_err", 64'(err), 64'd0);

        // reset mid-SQ
        do_start(32'd5, 32'd6, 32'd23);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("t7_rst_busy", 64'(busy), 64'd0);
        chk("t7_rst_flags", {59'd0, key_vld, enc_go, done, pass, err}, 64'd0);
        g = go_cnt;
        d = dn_cnt;
        @(negedge clk);
        rst = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("t7_no_go", 64'(go_cnt), 64'(g));
        chk("t7_no_done", 64'(dn_cnt), 64'(d));

        // start pulsed mid-run is ignored
        do_start(32'd5, 32'd6, 32'd23);
        repeat (2) @(posedge clk);
        @(negedge clk);
        base = 32'd2; priv = 32'd0; p = 32'd11; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_go(k);
        chk("t8_go_lat", 64'(k + 3), 64'(LAT_P6));
        chk("t8_key", key, 64'd8);
        respond(1'b1);
        // start during DONE is ignored
        base = 32'd27; priv = 32'd1; p = 32'd23; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("t8_done", 64'(done), 64'd1);
        chk("t8_pass", 64'(pass), 64'd1);
        @(posedge clk); #1;
        chk("t8_done_start_ign", 64'(busy), 64'd0);

        // a fresh start in IDLE recomputes correctly
        do_start(32'd27, 32'd1, 32'd23);
        wait_go(k);
        chk("t9_go_lat", 64'(k), 64'(LAT_P1));
        chk("t9_key", key, 64'd4);
        respond(1'b1);
        wait_done(k);
        chk("t9_pass", 64'(pass), 64'd1);
        chk("t9_err", 64'(err), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
